hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide execution unit with the architectural HI/LO registers.
- Sits directly downstream of the control decoder. Consumes its muxfour, hiw, low, hir and lor controls plus the register-file operands rs and rt.
- Executes MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Drives a busy stall back to the pipeline and returns HI/LO read data to the writeback mux.

Parameters:
- WIDTH, 32, operand and HI/LO width. Also sets the iteration count; one bit is processed per cycle.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- op_valid  input  1  current decoded instruction is valid this cycle
- muxfour  input  2  operation select: 0 none, 1 multu, 2 div, 3 divu
- hiw  input  1  HI write request
- low  input  1  LO write request
- hir  input  1  HI read select (mfhi)
- lor  input  1  LO read select (mflo)
- rs  input  WIDTH  operand A: dividend / multiplicand / mthi-mtlo source
- rt  input  WIDTH  operand B: divisor / multiplier
- rdata  output  WIDTH  read data: HI if hir, else LO if lor, else 0
- hi_out  output  WIDTH  committed HI register
- lo_out  output  WIDTH  committed LO register
- busy  output  1  iterative operation in progress; pipeline must stall
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result

Behaviour:
- Reset (rst_n=0 at a clock edge): HI=0, LO=0, busy=0, done=0, counter=0, datapath registers=0. Reset mid-operation aborts the operation; no partial result is committed.
- States: IDLE, RUN.
- IDLE -> RUN:
  - Triggered at an edge with op_valid=1 and muxfour!=0.
  - Operands latched: absolute values for div; raw values for multu and divu.
  - Operand signs latched.
  - Counter cleared; busy=1 from the next cycle.
- RUN iteration:
  - One iteration per edge, counter increments.
  - multu: shift-add; 2*WIDTH-bit product accumulator.
  - div/divu: restoring division; WIDTH-bit remainder and WIDTH-bit quotient.
- RUN completion (edge with counter==WIDTH-1):
  - Final iteration performed and HI/LO written in the same edge.
  - multu: HI=product[2W-1:W], LO=product[W-1:0].
  - divu: LO=quotient, HI=remainder.
  - div: quotient negated if the signs of rs and rt differ; remainder takes the sign of rs.
  - Unit returns to IDLE: busy=0, done=1 for exactly one cycle.
- Latency: busy is high for exactly WIDTH cycles. The result is visible on hi_out/lo_out in the cycle done=1.
- Divide by zero (rt=0, div or divu): no trap. LO=all-ones, HI=rs (original signed value for div). Full WIDTH cycles are still taken.
- Signed overflow (div with rs=0x80000000, rt=0xFFFFFFFF): LO=0x80000000, HI=0.
- mthi/mtlo (op_valid=1, muxfour=0, hiw or low set):
  - Written at the next edge from rs; hiw and low may both be set.
  - Ignored while busy=1; the pipeline is required to stall, and the unit does not queue the write.
- Priority: when muxfour!=0, hiw and low are treated as part of the mul/div op and do not write rs directly.
- New mul/div requests while busy=1 are ignored.
- rdata is combinational from the committed HI/LO. hir has priority over lor. During RUN, rdata returns the pre-operation values.
- hi_out and lo_out are direct register outputs.

Optional Feature:
- Macro: HILO_FAST_MULTU_EN.
- Defined:
  - multu completes in one cycle using a single-cycle WIDTH x WIDTH multiplier.
  - HI/LO are written at the start edge; busy stays 0; done pulses in the following cycle.
  - div and divu are unchanged.
- Undefined: multu uses the WIDTH-cycle iterative path described above.

Test Plan:
- Reset: drive rst_n=0 during a running divu, then release -> HI=0, LO=0, busy=0, done=0; no commit afterwards.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF:
  - Without macro: busy high for 32 cycles, then done -> HI=0xFFFFFFFE, LO=0x00000001.
  - With macro: same values with busy=0 throughout.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); also 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu rs=100, rt=0 -> after 32 busy cycles LO=0xFFFFFFFF, HI=100.
- mthi rs=0x12345678, then mtlo rs=0xCAFEBABE, then mfhi and mflo -> rdata=0x12345678, then 0xCAFEBABE.
- Issue divu 10/3; pulse mtlo rs=0xDEAD mid-run with hir=1 -> the write is ignored, rdata shows the old HI while busy, then the final result is LO=3, HI=1.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_if
// Bundles the decoder/register-file side of the HI/LO multiply-divide unit.
//   op_valid  : decoded instruction valid this cycle
//   muxfour   : 0 none, 1 multu, 2 div, 3 divu
//   hiw / low : mthi / mtlo write requests
//   hir / lor : mfhi / mflo read selects
//   rs / rt   : register-file operands
//   rdata     : selected HI/LO read data
//   hi_out    : committed HI register
//   lo_out    : committed LO register
//   busy      : iterative operation in progress (pipeline stall)
//   done      : one-cycle pulse when a new mul/div result appears on HI/LO
// master = pipeline side, slave = execution unit.
// ----------------------------------------------------------------------------
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [1:0]       muxfour;
    logic             hiw;
    logic             low;
    logic             hir;
    logic             lor;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;

    modport master (
        output op_valid, muxfour, hiw, low, hir, lor, rs, rt,
        input  rdata, hi_out, lo_out, busy, done
    );

    modport slave (
        input  op_valid, muxfour, hiw, low, hir, lor, rs, rt,
        output rdata, hi_out, lo_out, busy, done
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_unit
// Iterative MULTU / DIV / DIVU unit holding the architectural HI/LO registers,
// plus MTHI / MTLO writes and MFHI / MFLO reads.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : hilo_muldiv_if.slave (controls, operands, read data, status)
// One result bit is produced per cycle, so an iterative op keeps busy high
// for exactly WIDTH cycles and commits HI/LO on its last iteration edge.
// Optional macro HILO_FAST_MULTU_EN: multu completes at the start edge with
// a single-cycle multiplier (busy stays low); div/divu are unaffected.
// ----------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    hilo_muldiv_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0]       OP_NONE  = 2'd0;
    localparam logic [1:0]       OP_MULTU = 2'd1;
    localparam logic [1:0]       OP_DIV   = 2'd2;
    localparam logic [1:0]       OP_DIVU  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two's-complement negate when neg is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        cond_neg = neg ? (-v) : v;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;          // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {upper, lower}: product or {rem, quo}
    logic [WIDTH-1:0]   rs_q, rs_d;        // original rs, returned in HI on /0
    logic               rs_sgn_q, rs_sgn_d;
    logic               rt_sgn_q, rt_sgn_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic               fast_mul_s;
    logic [2*WIDTH-1:0] fast_prod_s;

`ifdef HILO_FAST_MULTU_EN
    assign fast_mul_s  = (bus.muxfour == OP_MULTU);
    assign fast_prod_s = {{WIDTH{1'b0}}, bus.rs} * {{WIDTH{1'b0}}, bus.rt};
`else
    assign fast_mul_s  = 1'b0;
    assign fast_prod_s = '0;
`endif

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    // Restoring division: bring the next dividend bit into the remainder.
    assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // MSB set means the trial subtraction borrowed (remainder < divisor).
    assign div_diff_s  = div_shift_s - {1'b0, a_q};

    // One iteration of the selected algorithm.
    always_comb begin
        step_acc_s = acc_q;
        if (op_q == OP_MULTU) begin
            step_acc_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        end else if (div_diff_s[WIDTH]) begin
            step_acc_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            step_acc_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state, operand capture, iteration and HI/LO commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        acc_d    = acc_q;
        rs_d     = rs_q;
        rs_sgn_d = rs_sgn_q;
        rt_sgn_d = rt_sgn_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid && (bus.muxfour != OP_NONE)) begin
                    if (fast_mul_s) begin
                        hi_d   = fast_prod_s[2*WIDTH-1:WIDTH];
                        lo_d   = fast_prod_s[WIDTH-1:0];
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        op_d     = bus.muxfour;
                        rs_d     = bus.rs;
                        rs_sgn_d = bus.rs[WIDTH-1];
                        rt_sgn_d = bus.rt[WIDTH-1];
                        case (bus.muxfour)
                            OP_MULTU: begin
                                a_d   = bus.rs;
                                acc_d = {{WIDTH{1'b0}}, bus.rt};
                            end
                            OP_DIV: begin
                                a_d   = cond_neg(bus.rt, bus.rt[WIDTH-1]);
                                acc_d = {{WIDTH{1'b0}}, cond_neg(bus.rs, bus.rs[WIDTH-1])};
                            end
                            default: begin
                                a_d   = bus.rt;
                                acc_d = {{WIDTH{1'b0}}, bus.rs};
                            end
                        endcase
                    end
                end else if (bus.op_valid) begin
                    // mthi / mtlo; both may be set together
                    if (bus.hiw) begin
                        hi_d = bus.rs;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.low) begin
                        lo_d = bus.rs;
                    end else begin
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                acc_d = step_acc_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULTU: begin
                            hi_d = step_acc_s[2*WIDTH-1:WIDTH];
                            lo_d = step_acc_s[WIDTH-1:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (a_q == '0) begin
                                lo_d = '1;
                                hi_d = rs_q;
                            end else if (op_q == OP_DIV) begin
                                lo_d = cond_neg(step_acc_s[WIDTH-1:0], rs_sgn_q ^ rt_sgn_q);
                                hi_d = cond_neg(step_acc_s[2*WIDTH-1:WIDTH], rs_sgn_q);
                            end else begin
                                lo_d = step_acc_s[WIDTH-1:0];
                                hi_d = step_acc_s[2*WIDTH-1:WIDTH];
                            end
                        end
                        default: begin
                            hi_d = hi_q;
                            lo_d = lo_q;
                        end
                    endcase
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_NONE;
            a_q      <= '0;
            acc_q    <= '0;
            rs_q     <= '0;
            rs_sgn_q <= 1'b0;
            rt_sgn_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            rs_q     <= rs_d;
            rs_sgn_q <= rs_sgn_d;
            rt_sgn_q <= rt_sgn_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Reads always see committed HI/LO, so a running op shows old values.
    assign bus.rdata  = bus.hir ? hi_q : (bus.lor ? lo_q : '0);
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
// Directed self-checking bench for hilo_muldiv_unit. Inputs change on the
// falling edge; outputs are sampled on the falling edge (or #1 after an input
// change for the combinational read path).
// ----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

`ifdef HILO_FAST_MULTU_EN
    localparam int MULTU_BUSY = 0;
`else
    localparam int MULTU_BUSY = 32;
`endif

    hilo_muldiv_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0;
        bus.muxfour  = 2'd0;
        bus.hiw      = 1'b0;
        bus.low      = 1'b0;
        bus.hir      = 1'b0;
        bus.lor      = 1'b0;
        bus.rs       = 32'h0;
        bus.rt       = 32'h0;
    endtask

    // mthi / mtlo for one cycle
    task automatic move_to(input logic hw, input logic lw, input logic [31:0] val);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.muxfour  = 2'd0;
        bus.hiw      = hw;
        bus.low      = lw;
        bus.rs       = val;
        @(negedge clk);
        idle_inputs();
    endtask

    // Issue a mul/div for one cycle; returns just after the start edge.
    task automatic start_op(input logic [1:0] mux, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.muxfour  = mux;
        bus.rs       = a;
        bus.rt       = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.muxfour  = 2'd0;
    endtask

    // Wait for done (bounded), counting the busy cycles seen on the way.
    task automatic run_to_done(input string tag, output int nbusy);
        int guard;
        nbusy = 0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 200) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            guard++;
        end
        check_val({tag, "_done_seen"}, 32'(bus.done), 32'h1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] mux,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int nb;
        start_op(mux, a, b);
        run_to_done(tag, nb);
        check_val({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        check_val({tag, "_hi"}, bus.hi_out, exp_hi);
        check_val({tag, "_lo"}, bus.lo_out, exp_lo);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 32'(bus.done), 32'h0);
    endtask

    initial begin
        int nb;
        int seen_done;
        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_init_hi", bus.hi_out, 32'h0);
        check_val("rst_init_lo", bus.lo_out, 32'h0);
        check_val("rst_init_busy", 32'(bus.busy), 32'h0);

        // Reset in the middle of a divu aborts it without a commit.
        move_to(1'b1, 1'b1, 32'h0000_0055);
        start_op(2'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        check_val("abort_busy_before", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("abort_hi", bus.hi_out, 32'h0);
        check_val("abort_lo", bus.lo_out, 32'h0);
        check_val("abort_busy", 32'(bus.busy), 32'h0);
        check_val("abort_done", 32'(bus.done), 32'h0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        check_val("abort_no_commit", 32'(seen_done), 32'h0);
        check_val("abort_hi_after", bus.hi_out, 32'h0);

        // mthi / mtlo then mfhi / mflo
        move_to(1'b1, 1'b0, 32'h1234_5678);
        move_to(1'b0, 1'b1, 32'hCAFE_BABE);
        bus.hir = 1'b1;
        #1 check_val("mfhi", bus.rdata, 32'h1234_5678);
        bus.hir = 1'b0;
        bus.lor = 1'b1;
        #1 check_val("mflo", bus.rdata, 32'hCAFE_BABE);
        bus.hir = 1'b1;
        #1 check_val("rd_hi_priority", bus.rdata, 32'h1234_5678);
        bus.hir = 1'b0;
        bus.lor = 1'b0;
        #1 check_val("rd_none", bus.rdata, 32'h0);
        move_to(1'b1, 1'b1, 32'h0BAD_F00D);
        check_val("mt_both_hi", bus.hi_out, 32'h0BAD_F00D);
        check_val("mt_both_lo", bus.lo_out, 32'h0BAD_F00D);

        // Multiply / divide vectors
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULTU_BUSY, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("multu_x16", 2'd1, 32'h1234_5678, 32'h0000_0010, MULTU_BUSY, 32'h0000_0001, 32'h2345_6780);
        run_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0000_0000, 32'h8000_0000);
        run_op("div_7_neg2", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_by0", 2'd3, 32'd100, 32'h0, 32, 32'd100, 32'hFFFF_FFFF);
        run_op("div_by0", 2'd2, 32'hFFFF_FFFB, 32'h0, 32, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("divu_big", 2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32, 32'h0000_000F, 32'h0FFF_FFFF);

        // divu 10/3 with mtlo and a new multu dropped while busy
        move_to(1'b1, 1'b1, 32'hAAAA_5555);
        start_op(2'd3, 32'd10, 32'd3);
        repeat (3) @(negedge clk);
        bus.op_valid = 1'b1;
        bus.low      = 1'b1;
        bus.rs       = 32'h0000_DEAD;
        bus.hir      = 1'b1;
        #1 check_val("busy_rd_old_hi", bus.rdata, 32'hAAAA_5555);
        @(negedge clk);
        bus.low     = 1'b0;
        bus.muxfour = 2'd1;
        bus.rs      = 32'h2;
        bus.rt      = 32'h2;
        check_val("busy_mtlo_ignored", bus.lo_out, 32'hAAAA_5555);
        @(negedge clk);
        idle_inputs();
        bus.hir = 1'b1;
        run_to_done("divu_10_3", nb);
        check_val("divu_10_3_busy_cycles", 32'(nb), 32'd27);
        check_val("divu_10_3_lo", bus.lo_out, 32'h3);
        check_val("divu_10_3_hi", bus.hi_out, 32'h1);
        #1 check_val("divu_10_3_rd", bus.rdata, 32'h1);
        @(negedge clk);
        check_val("divu_10_3_no_restart", 32'(bus.busy), 32'h0);
        check_val("divu_10_3_lo_kept", bus.lo_out, 32'h3);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
